// File: rtl/screen_flow_controller.sv
// Screen sequencing FSM (welcome/play/pause/end) with key edge detection and end-screen hold timer.
// State moves on the edge that samples a key press; the registered outputs follow one edge later.
module screen_flow_controller #(
  parameter int LIFE_W          = 4,
  parameter int NUM_LEVELS      = 4,
  parameter int END_HOLD_FRAMES = 120,
  parameter int PAUSE_EN        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic              key_start,
  input  logic              key_pause,
  input  logic [LIFE_W-1:0] life,
  input  logic              level_done,
  output logic [1:0]        screen_sel,
  output logic              start,
  output logic              game_end,
  output logic              paused,
  output logic              game_win,
  output logic [3:0]        level,
  output logic              game_reset
);

  // Encodings chosen to equal the screen_sel code of each state.
  localparam logic [1:0] S_WELCOME = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_END     = 2'd2;
  localparam logic [1:0] S_PAUSE   = 2'd3;

  localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [7:0] HOLD_MAX   = 8'(END_HOLD_FRAMES);
  localparam logic       PAUSE_ON   = (PAUSE_EN != 0);

  logic       r_start_q;
  logic       r_pause_q;
  logic       r_start_arm;
  logic       r_pause_arm;
  logic [1:0] r_state;
  logic [3:0] r_level;
  logic       r_win;
  logic       r_grst;
  logic [7:0] r_hold;

  logic       w_start_press;
  logic       w_pause_press;
  logic       w_life_zero;
  logic [1:0] w_state_nxt;
  logic [3:0] w_level_nxt;
  logic       w_win_nxt;
  logic       w_grst_nxt;
  logic [7:0] w_hold_nxt;

  // A key held across reset stays disarmed until it has been seen released.
  assign w_start_press = key_start & ~r_start_q & r_start_arm;
  assign w_pause_press = key_pause & ~r_pause_q & r_pause_arm;
  assign w_life_zero   = (life == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q   <= 1'b0;
      r_pause_q   <= 1'b0;
      r_start_arm <= 1'b0;
      r_pause_arm <= 1'b0;
    end else begin
      r_start_q   <= key_start;
      r_pause_q   <= key_pause;
      r_start_arm <= r_start_arm | ~key_start;
      r_pause_arm <= r_pause_arm | ~key_pause;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_win_nxt   = r_win;
    w_grst_nxt  = 1'b0;
    w_hold_nxt  = 8'd0;
    case (r_state)
      S_WELCOME: begin
        if (w_start_press) begin
          w_state_nxt = S_PLAY;
          w_level_nxt = 4'd0;
          w_win_nxt   = 1'b0;
          w_grst_nxt  = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_life_zero) begin
          w_state_nxt = S_END;
          w_win_nxt   = 1'b0;
        end else if (level_done) begin
          if (r_level == LAST_LEVEL) begin
            w_state_nxt = S_END;
            w_win_nxt   = 1'b1;
          end else begin
            w_level_nxt = r_level + 4'd1;
            w_grst_nxt  = 1'b1;
          end
        end else if (w_pause_press && PAUSE_ON) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_life_zero) begin
          w_state_nxt = S_END;
          w_win_nxt   = 1'b0;
        end else if (w_pause_press) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_END: begin
        // Early start presses fall through and are simply lost.
        w_hold_nxt = r_hold;
        if (w_start_press && (r_hold == HOLD_MAX)) begin
          w_state_nxt = S_WELCOME;
        end else if (startOfFrame && (r_hold < HOLD_MAX)) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_WELCOME;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WELCOME;
      r_level <= 4'd0;
      r_win   <= 1'b0;
      r_grst  <= 1'b0;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_win   <= w_win_nxt;
      r_grst  <= w_grst_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      screen_sel <= S_WELCOME;
      start      <= 1'b0;
      game_end   <= 1'b0;
      paused     <= 1'b0;
      game_win   <= 1'b0;
      level      <= 4'd0;
      game_reset <= 1'b0;
    end else begin
      screen_sel <= r_state;
      start      <= (r_state == S_PLAY) || (r_state == S_PAUSE);
      game_end   <= (r_state == S_END);
      paused     <= (r_state == S_PAUSE);
      game_win   <= r_win;
      level      <= r_level;
      game_reset <= r_grst;
    end
  end

endmodule

// File: tb/tb_screen_flow_controller.sv
// Bench for screen_flow_controller: two instances (pause enabled / disabled) against a rule-level model.
module tb_screen_flow_controller;

  localparam int NLEV = 4;
  localparam int HOLD = 3;
  localparam int M_W  = 0;
  localparam int M_P  = 1;
  localparam int M_E  = 2;
  localparam int M_Z  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sof = 1'b0;
  logic       key_start = 1'b0;
  logic       key_pause = 1'b0;
  logic       level_done = 1'b0;
  logic [3:0] life = 4'd3;

  logic [1:0] a_sel, b_sel;
  logic       a_start, a_end, a_paused, a_win, a_grst;
  logic       b_start, b_end, b_paused, b_win, b_grst;
  logic [3:0] a_lvl, b_lvl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  screen_flow_controller #(.LIFE_W(4), .NUM_LEVELS(NLEV), .END_HOLD_FRAMES(HOLD), .PAUSE_EN(1)) dut_a (
    .clk(clk), .reset(reset), .startOfFrame(sof), .key_start(key_start), .key_pause(key_pause),
    .life(life), .level_done(level_done), .screen_sel(a_sel), .start(a_start), .game_end(a_end),
    .paused(a_paused), .game_win(a_win), .level(a_lvl), .game_reset(a_grst));

  screen_flow_controller #(.LIFE_W(4), .NUM_LEVELS(NLEV), .END_HOLD_FRAMES(HOLD), .PAUSE_EN(0)) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(sof), .key_start(key_start), .key_pause(key_pause),
    .life(life), .level_done(level_done), .screen_sel(b_sel), .start(b_start), .game_end(b_end),
    .paused(b_paused), .game_win(b_win), .level(b_lvl), .game_reset(b_grst));

  typedef struct {
    int st;
    int lvl;
    bit win;
    int hold;
    bit grst;
    bit ks_prev;
    bit kp_prev;
  } mdl_t;

  typedef struct packed {
    logic [1:0] sel;
    logic       start;
    logic       game_end;
    logic       paused;
    logic       win;
    logic [3:0] lvl;
    logic       grst;
  } obs_t;

  mdl_t m_a, m_b;
  obs_t e_a, e_b;

  // Keys count as "previously held" after reset, so holding one through reset is no press.
  function automatic mdl_t model_reset();
    mdl_t m;
    m.st = M_W; m.lvl = 0; m.win = 1'b0; m.hold = 0; m.grst = 1'b0;
    m.ks_prev = 1'b1; m.kp_prev = 1'b1;
    return m;
  endfunction

  function automatic mdl_t model_step(mdl_t m, bit pen, bit ks, bit kp, bit ld, bit fr, logic [3:0] lf);
    bit sp;
    bit pp;
    sp = ks && !m.ks_prev;
    pp = kp && !m.kp_prev;
    m.ks_prev = ks;
    m.kp_prev = kp;
    m.grst = 1'b0;
    if (m.st == M_W) begin
      if (sp) begin m.st = M_P; m.lvl = 0; m.win = 1'b0; m.grst = 1'b1; end
    end else if (m.st == M_P) begin
      if (lf == 0) begin m.st = M_E; m.win = 1'b0; m.hold = 0; end
      else if (ld && m.lvl == NLEV - 1) begin m.st = M_E; m.win = 1'b1; m.hold = 0; end
      else if (ld) begin m.lvl = m.lvl + 1; m.grst = 1'b1; end
      else if (pp && pen) m.st = M_Z;
    end else if (m.st == M_Z) begin
      if (lf == 0) begin m.st = M_E; m.win = 1'b0; m.hold = 0; end
      else if (pp) m.st = M_P;
    end else begin
      if (sp && m.hold == HOLD) m.st = M_W;
      else if (fr && m.hold < HOLD) m.hold = m.hold + 1;
    end
    return m;
  endfunction

  function automatic obs_t model_view(mdl_t m);
    obs_t o;
    o.sel      = 2'(m.st);
    o.start    = (m.st == M_P) || (m.st == M_Z);
    o.game_end = (m.st == M_E);
    o.paused   = (m.st == M_Z);
    o.win      = m.win;
    o.lvl      = 4'(m.lvl);
    o.grst     = m.grst;
    return o;
  endfunction

  // Outputs trail the model state by one edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a = model_reset();
      m_b = model_reset();
      e_a = model_view(m_a);
      e_b = model_view(m_b);
    end else begin
      e_a = model_view(m_a);
      e_b = model_view(m_b);
      m_a = model_step(m_a, 1'b1, key_start, key_pause, level_done, sof, life);
      m_b = model_step(m_b, 1'b0, key_start, key_pause, level_done, sof, life);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("A.sel", 8'(a_sel), 8'(e_a.sel));
    chk("A.start", 8'(a_start), 8'(e_a.start));
    chk("A.game_end", 8'(a_end), 8'(e_a.game_end));
    chk("A.paused", 8'(a_paused), 8'(e_a.paused));
    chk("A.game_win", 8'(a_win), 8'(e_a.win));
    chk("A.level", 8'(a_lvl), 8'(e_a.lvl));
    chk("A.game_reset", 8'(a_grst), 8'(e_a.grst));
    chk("B.sel", 8'(b_sel), 8'(e_b.sel));
    chk("B.start", 8'(b_start), 8'(e_b.start));
    chk("B.game_end", 8'(b_end), 8'(e_b.game_end));
    chk("B.paused", 8'(b_paused), 8'(e_b.paused));
    chk("B.game_win", 8'(b_win), 8'(e_b.win));
    chk("B.level", 8'(b_lvl), 8'(e_b.lvl));
    chk("B.game_reset", 8'(b_grst), 8'(e_b.grst));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1 reset = 1'b1;
    tick();
    chk("rst_sel", 8'(a_sel), 8'd0);
    chk("rst_flags", {4'd0, a_start, a_end, a_paused, a_win}, 8'd0);
    chk("rst_level", 8'(a_lvl), 8'd0);
    chk("rst_game_reset", 8'(a_grst), 8'd0);
    reset = 1'b0;
    ticks(2);

    // Welcome -> play with one game_reset pulse.
    key_start = 1'b1; tick();
    key_start = 1'b0; tick();
    chk("play_sel", 8'(a_sel), 8'd1);
    chk("play_start", 8'(a_start), 8'd1);
    chk("play_grst_on", 8'(a_grst), 8'd1);
    chk("play_level", 8'(a_lvl), 8'd0);
    tick();
    chk("play_grst_off", 8'(a_grst), 8'd0);

    // Clear all four levels.
    for (int i = 0; i < 3; i++) begin
      level_done = 1'b1; tick();
      level_done = 1'b0; ticks(2);
    end
    chk("lvl_3", 8'(a_lvl), 8'd3);
    level_done = 1'b1; tick();
    level_done = 1'b0; tick();
    chk("win_sel", 8'(a_sel), 8'd2);
    chk("win_flag", 8'(a_win), 8'd1);
    chk("win_end", 8'(a_end), 8'd1);
    chk("win_level", 8'(a_lvl), 8'd3);

    // End-screen hold: press after 2 frames is dropped, after 3 accepted.
    for (int i = 0; i < 2; i++) begin
      sof = 1'b1; tick();
      sof = 1'b0; tick();
    end
    key_start = 1'b1; tick();
    key_start = 1'b0; ticks(2);
    chk("hold_early", 8'(a_sel), 8'd2);
    sof = 1'b1; tick();
    sof = 1'b0; tick();
    key_start = 1'b1; tick();
    key_start = 1'b0; tick();
    chk("hold_done", 8'(a_sel), 8'd0);

    // Pause toggle; instance B ignores pause.
    key_start = 1'b1; tick();
    key_start = 1'b0; ticks(2);
    key_pause = 1'b1; tick();
    key_pause = 1'b0; tick();
    chk("pause_sel", 8'(a_sel), 8'd3);
    chk("pause_flag", 8'(a_paused), 8'd1);
    chk("nopause_sel", 8'(b_sel), 8'd1);
    key_pause = 1'b1; tick();
    key_pause = 1'b0; tick();
    chk("unpause_sel", 8'(a_sel), 8'd1);

    // Life lost while paused beats a simultaneous pause press.
    key_pause = 1'b1; tick();
    key_pause = 1'b0; ticks(2);
    life = 4'd0; key_pause = 1'b1; tick();
    key_pause = 1'b0; tick();
    chk("pause_die_sel", 8'(a_sel), 8'd2);
    chk("pause_die_win", 8'(a_win), 8'd0);
    chk("play_die_sel", 8'(b_sel), 8'd2);
    life = 4'd3;

    // Start key held across reset must not count.
    key_start = 1'b1; reset = 1'b1; tick();
    chk("midrst_sel", 8'(a_sel), 8'd0);
    reset = 1'b0; ticks(4);
    chk("held_key_sel", 8'(a_sel), 8'd0);
    key_start = 1'b0; tick();
    key_start = 1'b1; tick();
    key_start = 1'b0; tick();
    chk("repress_sel", 8'(a_sel), 8'd1);

    // Zero lives on entry to play ends the game one cycle later.
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    life = 4'd0; key_start = 1'b1; tick();
    key_start = 1'b0; tick();
    chk("zero_life_play", 8'(a_sel), 8'd1);
    tick();
    chk("zero_life_end", 8'(a_sel), 8'd2);
    life = 4'd3;

    // Randomised traffic checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      key_start  = ($urandom_range(0, 3) == 0);
      key_pause  = ($urandom_range(0, 4) == 0);
      level_done = ($urandom_range(0, 7) == 0);
      sof        = ($urandom_range(0, 2) == 0);
      life       = ($urandom_range(0, 40) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      reset      = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
